// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads a word from combinational imem each cycle
// and buffers {pc, instr} pairs in a small FIFO that decode drains via valid/ready.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] fpc_q, fpc_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pcMem_q [DEPTH];
  logic [31:0] instrMem_q [DEPTH];

  logic push;
  logic pop;

  assign imem_addr = fpc_q;
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_instr = out_valid ? instrMem_q[rdPtr_q] : NOP;
  assign out_pc    = out_valid ? pcMem_q[rdPtr_q] : 32'h0;

  // A full queue may still accept a word when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = !redirect & (!full | pop);

  always_comb begin
    fpc_d   = fpc_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (redirect) begin
      fpc_d   = redirect_pc & 32'hFFFF_FFFC;
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + AW'(1);
        fpc_d   = fpc_q + 32'd4;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pcMem_q[wrPtr_q]    <= fpc_q;
      instrMem_q[wrPtr_q] <= imem_rdata;
    end
  end

endmodule
